// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and helpers for the issue/retire hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 0;

  // x0 is hard-wired to zero, so writes to it never create an outstanding result.
  function automatic logic is_tracked(input logic [REG_ADDR_W-1:0] addr);
    return (addr != REG_ADDR_W'(ZERO_REG));
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// Per-register pending-write counter: up/down with synchronous clear and an
// underflow indication when a decrement hits an empty counter.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             uf_s;

  // Next count: clear wins, simultaneous inc/dec cancel, underflow holds at zero.
  always_comb begin
    cnt_d = cnt_q;
    uf_s  = 1'b0;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc && !dec) begin
      if (cnt_q == {CNT_W{1'b1}}) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (dec && !inc) begin
      if (cnt_q == {CNT_W{1'b0}}) begin
        cnt_d = cnt_q;
        uf_s  = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt       = cnt_q;
  assign underflow = uf_s;

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue/retire scoreboard: tracks outstanding register writes between decode
// and write-back, and stalls fetch/decode on RAW, WAW saturation or capacity.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int INF_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_rs1_r_ena,
  input  logic [REG_ADDR_W-1:0] id_rs1_r_addr,
  input  logic                  id_rs2_r_ena,
  input  logic [REG_ADDR_W-1:0] id_rs2_r_addr,
  input  logic                  id_rd_w_ena,
  input  logic [REG_ADDR_W-1:0] id_rd_w_addr,
  output logic                  id_ready,
  output logic                  stall_if,
  output logic                  stall_id,
  input  logic                  wb_valid,
  input  logic                  wb_rd_w_ena,
  input  logic [REG_ADDR_W-1:0] wb_rd_w_addr,
  input  logic                  flush,
  output logic [INF_W-1:0]      inflight_cnt,
  output logic                  sb_err
);

  logic [CNT_W-1:0]    pend_s [NUM_REGS];
  logic [NUM_REGS-1:1] reg_inc_s;
  logic [NUM_REGS-1:1] reg_dec_s;
  logic [NUM_REGS-1:1] reg_uf_s;

  logic raw_s;
  logic waw_s;
  logic cap_s;
  logic ready_s;
  logic issue_fire_s;
  logic trk_inc_s;
  logic trk_dec_s;
  logic inf_uf_s;

  logic [INF_W-1:0] inflight_d;
  logic [INF_W-1:0] inflight_q;
  logic             sb_err_d;
  logic             sb_err_q;

  // x0 has no counter; reading it through the table always yields zero.
  assign pend_s[0] = {CNT_W{1'b0}};

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
    sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .inc       (reg_inc_s[r]),
      .dec       (reg_dec_s[r]),
      .cnt       (pend_s[r]),
      .underflow (reg_uf_s[r])
    );
  end

  // Hazard detection from registered counts only; a same-cycle retire does not help.
  always_comb begin
    raw_s = 1'b0;
    waw_s = 1'b0;
    cap_s = 1'b0;
    if (id_rs1_r_ena && is_tracked(id_rs1_r_addr) &&
        (pend_s[id_rs1_r_addr] != {CNT_W{1'b0}})) begin
      raw_s = 1'b1;
    end else if (id_rs2_r_ena && is_tracked(id_rs2_r_addr) &&
                 (pend_s[id_rs2_r_addr] != {CNT_W{1'b0}})) begin
      raw_s = 1'b1;
    end else begin
      raw_s = 1'b0;
    end
    if (id_rd_w_ena && is_tracked(id_rd_w_addr)) begin
      waw_s = (pend_s[id_rd_w_addr] == {CNT_W{1'b1}});
      cap_s = (inflight_q == INF_W'(MAX_INFLIGHT));
    end else begin
      waw_s = 1'b0;
      cap_s = 1'b0;
    end
  end

  assign ready_s      = !flush && !raw_s && !waw_s && !cap_s;
  assign issue_fire_s = id_valid && ready_s;
  assign trk_inc_s    = issue_fire_s && id_rd_w_ena && is_tracked(id_rd_w_addr);
  // Retires are discarded in a flush cycle so they cannot underflow cleared state.
  assign trk_dec_s    = wb_valid && wb_rd_w_ena && is_tracked(wb_rd_w_addr) && !flush;

  // One-hot per-register increment/decrement strobes.
  always_comb begin
    reg_inc_s = {(NUM_REGS-1){1'b0}};
    reg_dec_s = {(NUM_REGS-1){1'b0}};
    for (int r = 1; r < NUM_REGS; r++) begin
      reg_inc_s[r] = trk_inc_s && (id_rd_w_addr == REG_ADDR_W'(r));
      reg_dec_s[r] = trk_dec_s && (wb_rd_w_addr == REG_ADDR_W'(r));
    end
  end

  // Global in-flight count, same inc/dec/underflow rules as the per-register counters.
  always_comb begin
    inflight_d = inflight_q;
    inf_uf_s   = 1'b0;
    if (flush) begin
      inflight_d = {INF_W{1'b0}};
    end else if (trk_inc_s && !trk_dec_s) begin
      inflight_d = inflight_q + INF_W'(1);
    end else if (trk_dec_s && !trk_inc_s) begin
      if (inflight_q == {INF_W{1'b0}}) begin
        inflight_d = inflight_q;
        inf_uf_s   = 1'b1;
      end else begin
        inflight_d = inflight_q - INF_W'(1);
      end
    end else begin
      inflight_d = inflight_q;
    end
  end

  // Sticky error: any underflow latches until reset; flush leaves it alone.
  always_comb begin
    sb_err_d = sb_err_q;
    if (inf_uf_s || (|reg_uf_s)) begin
      sb_err_d = 1'b1;
    end else begin
      sb_err_d = sb_err_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= {INF_W{1'b0}};
      sb_err_q   <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      sb_err_q   <= sb_err_d;
    end
  end

  assign id_ready     = ready_s;
  assign stall_if     = id_valid && !ready_s;
  assign stall_id     = id_valid && !ready_s;
  assign inflight_cnt = inflight_q;
  assign sb_err       = sb_err_q;

endmodule
